// File: rtl/lfsr_sync_checker.sv
// Receive-side checker for the 8-bit Galois LFSR stream: self-syncs, locks after a run of
// correct predictions, then flywheels on its own reference and counts mismatches.
module lfsr_sync_checker #(
  parameter int unsigned N_LOCK   = 5,
  parameter int unsigned N_UNLOCK = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [7:0]       i_lfsr,
  output logic             o_lock,
  output logic             o_mismatch,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [7:0]       o_expected
);

  localparam int unsigned GoodW = $clog2(N_LOCK + 1);
  localparam int unsigned BadW  = $clog2(N_UNLOCK + 1);

  typedef enum logic {StUnlocked, StLocked} state_e;

  // The (r[6:0]==0) term splices 0x00 into the cycle, giving period 256.
  function automatic logic [7:0] lfsr_next(input logic [7:0] r);
    logic f;
    f = r[7] ^ (r[6:0] == 7'd0);
    return {r[6], r[5], r[4], r[3] ^ f, r[2] ^ f, r[1] ^ f, r[0], f};
  endfunction

  state_e             state_q, state_d;
  logic               prim_q, prim_d;
  logic [7:0]         ref_q, ref_d;
  logic [GoodW-1:0]   good_q, good_d;
  logic [BadW-1:0]    bad_q, bad_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic               mismatch_q, mismatch_d;
  logic [7:0]         expected_q, expected_d;
  logic [7:0]         pred;
  logic               match;

  always_comb begin
    state_d    = state_q;
    prim_d     = prim_q;
    ref_d      = ref_q;
    good_d     = good_q;
    bad_d      = bad_q;
    err_d      = err_q;
    mismatch_d = 1'b0;
    pred       = lfsr_next(ref_q);
    match      = (i_lfsr == pred);

    if (i_valid) begin
      if (!prim_q) begin
        prim_d = 1'b1;
        ref_d  = i_lfsr;
      end else begin
        unique case (state_q)
          StUnlocked: begin
            ref_d = i_lfsr;
            if (match) begin
              if (good_q == GoodW'(N_LOCK - 1)) begin
                state_d = StLocked;
                good_d  = '0;
                bad_d   = '0;
              end else begin
                good_d = good_q + GoodW'(1);
              end
            end else begin
              good_d     = '0;
              mismatch_d = 1'b1;
            end
          end
          StLocked: begin
            // Flywheel: the reference advances on its own so line errors do not corrupt it.
            ref_d = pred;
            if (match) begin
              bad_d = '0;
            end else begin
              mismatch_d = 1'b1;
              if (err_q != {CNT_W{1'b1}}) err_d = err_q + CNT_W'(1);
              if (bad_q == BadW'(N_UNLOCK - 1)) begin
                state_d = StUnlocked;
                good_d  = '0;
                bad_d   = '0;
                ref_d   = i_lfsr;
              end else begin
                bad_d = bad_q + BadW'(1);
              end
            end
          end
        endcase
      end
    end

    expected_d = prim_d ? lfsr_next(ref_d) : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q    <= StUnlocked;
      prim_q     <= 1'b0;
      ref_q      <= 8'h00;
      good_q     <= '0;
      bad_q      <= '0;
      err_q      <= '0;
      mismatch_q <= 1'b0;
      expected_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      prim_q     <= prim_d;
      ref_q      <= ref_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      err_q      <= err_d;
      mismatch_q <= mismatch_d;
      expected_q <= expected_d;
    end
  end

  assign o_lock     = (state_q == StLocked);
  assign o_mismatch = mismatch_q;
  assign o_err_cnt  = err_q;
  assign o_expected = expected_q;

endmodule

// File: tb/tb_lfsr_sync_checker.sv
// Directed self-checking bench for lfsr_sync_checker with hand-computed LFSR sequences.
module tb_lfsr_sync_checker;

  logic        clk;
  logic        i_rst;
  logic        i_valid;
  logic [7:0]  i_lfsr;
  logic        o_lock;
  logic        o_mismatch;
  logic [15:0] o_err_cnt;
  logic [7:0]  o_expected;

  int total;
  int bad;

  lfsr_sync_checker #(
    .N_LOCK   (5),
    .N_UNLOCK (3),
    .CNT_W    (16)
  ) dut (
    .clk        (clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .i_lfsr     (i_lfsr),
    .o_lock     (o_lock),
    .o_mismatch (o_mismatch),
    .o_err_cnt  (o_err_cnt),
    .o_expected (o_expected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1ns after the edge; outputs are read at the same point.
  task automatic beat(input logic v, input logic [7:0] d);
    i_valid = v;
    i_lfsr  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    beat(1'b1, 8'h5A);
    beat(1'b1, 8'h5A);
    i_rst = 1'b0;
    i_valid = 1'b0;
  endtask

  task automatic lock_from_one();
    logic [7:0] seq [6];
    seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};
    for (int i = 0; i < 6; i++) beat(1'b1, seq[i]);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (o_lock !== 1'b0) begin bad++; $display("FAIL reset o_lock got=%b want=0", o_lock); end
    total++; if (o_mismatch !== 1'b0) begin bad++; $display("FAIL reset o_mismatch got=%b want=0", o_mismatch); end
    total++; if (o_err_cnt !== 16'd0) begin bad++; $display("FAIL reset o_err_cnt got=%0d want=0", o_err_cnt); end
    total++; if (o_expected !== 8'h00) begin bad++; $display("FAIL reset o_expected got=%h want=00", o_expected); end
  endtask

  task automatic test_clean_lock();
    logic [7:0] seq [6];
    logic [7:0] exp_nx [6];
    seq    = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};
    exp_nx = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};
    for (int i = 0; i < 6; i++) begin
      beat(1'b1, seq[i]);
      total++;
      if (o_lock !== (i == 5)) begin
        bad++; $display("FAIL clean_lock[%0d] o_lock got=%b want=%b", i, o_lock, (i == 5));
      end
      total++;
      if (o_mismatch !== 1'b0) begin
        bad++; $display("FAIL clean_lock[%0d] o_mismatch got=%b want=0", i, o_mismatch);
      end
      total++;
      if (o_expected !== exp_nx[i]) begin
        bad++; $display("FAIL clean_lock[%0d] o_expected got=%h want=%h", i, o_expected, exp_nx[i]);
      end
    end
    total++; if (o_err_cnt !== 16'd0) begin bad++; $display("FAIL clean_lock o_err_cnt got=%0d want=0", o_err_cnt); end
  endtask

  task automatic test_zero_path();
    logic [7:0] seq [4];
    seq = '{8'h40, 8'h80, 8'h00, 8'h1D};
    for (int i = 0; i < 4; i++) begin
      beat(1'b1, seq[i]);
      total++;
      if (o_mismatch !== 1'b0 || o_lock !== 1'b1) begin
        bad++; $display("FAIL zero_path[%0d] mismatch/lock got=%b%b want=01", i, o_mismatch, o_lock);
      end
    end
    total++; if (o_expected !== 8'h3A) begin bad++; $display("FAIL zero_path o_expected got=%h want=3a", o_expected); end
  endtask

  task automatic test_single_error();
    beat(1'b1, 8'hFF);  // 0x3A expected
    total++; if (o_mismatch !== 1'b1) begin bad++; $display("FAIL single_err o_mismatch got=%b want=1", o_mismatch); end
    total++; if (o_err_cnt !== 16'd1) begin bad++; $display("FAIL single_err o_err_cnt got=%0d want=1", o_err_cnt); end
    total++; if (o_lock !== 1'b1) begin bad++; $display("FAIL single_err o_lock got=%b want=1", o_lock); end
    total++; if (o_expected !== 8'h74) begin bad++; $display("FAIL single_err o_expected got=%h want=74", o_expected); end
    beat(1'b0, 8'h99);
    total++; if (o_mismatch !== 1'b0) begin bad++; $display("FAIL single_err gap o_mismatch got=%b want=0", o_mismatch); end
    total++; if (o_expected !== 8'h74) begin bad++; $display("FAIL single_err gap o_expected got=%h want=74", o_expected); end
    beat(1'b1, 8'h74);
    total++; if (o_mismatch !== 1'b0) begin bad++; $display("FAIL single_err resume o_mismatch got=%b want=0", o_mismatch); end
    total++; if (o_err_cnt !== 16'd1) begin bad++; $display("FAIL single_err resume o_err_cnt got=%0d want=1", o_err_cnt); end
    total++; if (o_expected !== 8'hE8) begin bad++; $display("FAIL single_err resume o_expected got=%h want=e8", o_expected); end
  endtask

  task automatic test_unlock_relock();
    logic [7:0] wrong [3];
    logic [7:0] clean [5];
    wrong = '{8'h11, 8'h22, 8'h33};
    clean = '{8'h66, 8'hCC, 8'h85, 8'h17, 8'h2E};  // continues from 0x33
    do_reset();
    lock_from_one();
    for (int i = 0; i < 3; i++) begin
      beat(1'b1, wrong[i]);
      total++;
      if (o_mismatch !== 1'b1) begin bad++; $display("FAIL unlock[%0d] o_mismatch got=%b want=1", i, o_mismatch); end
      total++;
      if (o_err_cnt !== 16'(i + 1)) begin
        bad++; $display("FAIL unlock[%0d] o_err_cnt got=%0d want=%0d", i, o_err_cnt, i + 1);
      end
      total++;
      if (o_lock !== (i != 2)) begin bad++; $display("FAIL unlock[%0d] o_lock got=%b want=%b", i, o_lock, (i != 2)); end
    end
    total++; if (o_expected !== 8'h66) begin bad++; $display("FAIL unlock o_expected got=%h want=66", o_expected); end
    for (int i = 0; i < 5; i++) begin
      beat(1'b1, clean[i]);
      total++;
      if (o_lock !== (i == 4)) begin bad++; $display("FAIL relock[%0d] o_lock got=%b want=%b", i, o_lock, (i == 4)); end
      total++;
      if (o_mismatch !== 1'b0) begin bad++; $display("FAIL relock[%0d] o_mismatch got=%b want=0", i, o_mismatch); end
    end
    total++; if (o_err_cnt !== 16'd3) begin bad++; $display("FAIL relock o_err_cnt got=%0d want=3", o_err_cnt); end
  endtask

  task automatic test_gaps();
    logic [7:0] seq [6];
    int gaps [6];
    seq  = '{8'hA5, 8'h57, 8'hAE, 8'h41, 8'h82, 8'h19};
    gaps = '{2, 0, 1, 3, 1, 2};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        beat(1'b0, 8'hFF);
        total++;
        if (o_lock !== 1'b0 || o_mismatch !== 1'b0) begin
          bad++; $display("FAIL gaps[%0d] idle lock/mismatch got=%b%b want=00", i, o_lock, o_mismatch);
        end
      end
      beat(1'b1, seq[i]);
      total++;
      if (o_lock !== (i == 5)) begin bad++; $display("FAIL gaps[%0d] o_lock got=%b want=%b", i, o_lock, (i == 5)); end
    end
    total++; if (o_expected !== 8'h32) begin bad++; $display("FAIL gaps o_expected got=%h want=32", o_expected); end
  endtask

  task automatic test_reset_locked();
    beat(1'b1, 8'hFF);  // one error so the reset has something to clear
    total++; if (o_err_cnt !== 16'd1) begin bad++; $display("FAIL rst_locked pre o_err_cnt got=%0d want=1", o_err_cnt); end
    i_rst = 1'b1;
    beat(1'b1, 8'h64);
    i_rst = 1'b0;
    total++; if (o_lock !== 1'b0) begin bad++; $display("FAIL rst_locked o_lock got=%b want=0", o_lock); end
    total++; if (o_err_cnt !== 16'd0) begin bad++; $display("FAIL rst_locked o_err_cnt got=%0d want=0", o_err_cnt); end
    total++; if (o_expected !== 8'h00) begin bad++; $display("FAIL rst_locked o_expected got=%h want=00", o_expected); end
    total++; if (o_mismatch !== 1'b0) begin bad++; $display("FAIL rst_locked o_mismatch got=%b want=0", o_mismatch); end
    test_clean_lock();
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_lfsr  = 8'h00;
    test_reset();
    test_clean_lock();
    test_zero_path();
    test_single_error();
    test_unlock_relock();
    test_gaps();
    test_reset_locked();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
